dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder on the processor's load/store interface: address comes from ALUOut, store data from WriteData, load data returns on ReadData.
- Holds a word-addressed RAM behind a configurable wait-state FSM.
- Drives Stall so the processor freezes PC and register writeback until the access completes.
- Flags misaligned and illegal requests.

Parameters:
- ADDR_WIDTH, 8, word-address bits; depth = 2**ADDR_WIDTH words.
- DATA_WIDTH, 32, word width.
- WAIT_STATES, 2, extra stall cycles per legal access; range 0..15.

Ports:
- CLK  input  1  single clock, rising edge.
- Reset  input  1  asynchronous, active-low reset (asserted when 0).
- MemRead  input  1  load request.
- MemWrite  input  1  store request.
- Addr  input  32  byte address (ALUOut).
- WriteData  input  DATA_WIDTH  store data.
- ReadData  output  DATA_WIDTH  registered load data.
- Ready  output  1  one-cycle pulse: access complete.
- Stall  output  1  processor must hold PC and state.
- AddrErr  output  1  one-cycle pulse with Ready: request rejected.

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous and active-low.
- Reset values: state=IDLE, wait counter=0, ReadData=0, Ready=0, AddrErr=0, Stall=0 (no request).
  - RAM contents are not reset; after reset they are undefined.
- Word index: Addr[ADDR_WIDTH+1:2]. Upper address bits are ignored, so addresses alias modulo depth.
- Request: MemRead|MemWrite is sampled in IDLE. The processor holds Addr, WriteData and the request stable while Stall=1.
- Stall is combinational: Stall = (state==IDLE && request) || state==WAIT. It is 0 in RESP.
- Legal request (exactly one of MemRead/MemWrite, Addr[1:0]==0), timeline:
  - cycle 0: IDLE. Capture Addr, WriteData and type. Load counter with WAIT_STATES.
  - cycles 1..WAIT_STATES: WAIT. Counter decrements each cycle.
  - On the edge leaving the last WAIT cycle (or leaving cycle 0 if WAIT_STATES=0):
    - a store commits to RAM;
    - a load registers RAM[index] into ReadData.
  - cycle WAIT_STATES+1: RESP. Ready=1, AddrErr=0. Request inputs are ignored.
  - The next edge returns to IDLE.
  - Total stall = WAIT_STATES+1 cycles.
- Illegal request (Addr[1:0]!=0, or MemRead and MemWrite both 1):
  - IDLE goes to RESP in one cycle; Stall=1 only in cycle 0.
  - In RESP: Ready=1, AddrErr=1.
  - No RAM write; ReadData unchanged.
- ReadData holds its value until the next completed legal load. Stores do not change it.
- Back-to-back accesses: the request seen in the cycle after RESP (IDLE) starts a new access. Minimum spacing is WAIT_STATES+2 cycles.
- No request in IDLE: remain in IDLE with all pulses low.
- Reset mid-access:
  - Asserted before the commit edge: the store is aborted (RAM unchanged) and ReadData=0.
  - Asserted after the commit edge: the store is kept.
- The store commits once only, regardless of how long the request stays high during RESP.

Decomposition:
- Package dmem_pkg holds:
  - state encoding IDLE=2'b00, WAIT=2'b01, RESP=2'b10;
  - WAIT counter width constant (4);
  - alignment mask constant 2'b00.
- Sub-module dmem_array: single-port RAM, synchronous write with write enable, synchronous registered read. Parameters ADDR_WIDTH and DATA_WIDTH.
- Top level holds the FSM, counter, request capture, error checks and Stall/Ready/AddrErr logic.

Test Plan:
- Reset: drive Reset=0 for 3 cycles with MemRead=1 -> ReadData=0, Ready=0, AddrErr=0, state IDLE. Release -> Stall=1 in the first cycle.
- WAIT_STATES=2: store 0xDEADBEEF to 0x10, then load 0x10.
  - Store: Stall high exactly 3 cycles, Ready pulses in cycle 3, AddrErr=0.
  - Load: ReadData=0xDEADBEEF with Ready in cycle 3.
- Misaligned load from 0x13 -> Stall for 1 cycle, Ready=AddrErr=1 in cycle 1, ReadData keeps 0xDEADBEEF.
  - Misaligned store 0x12 = 0x1 -> a subsequent load of 0x10 still returns 0xDEADBEEF.
- MemRead=MemWrite=1 at 0x20 with data 0x55 -> AddrErr pulse, no write; a later load of 0x20 returns its prior value.
- ADDR_WIDTH=8: store 0x12345678 to 0x410 -> load of 0x10 returns 0x12345678 (aliasing).
- Reset during WAIT of a store of 0xCAFEF00D to 0x30 (prior value 0x1) -> load of 0x30 after reset returns 0x1.
- WAIT_STATES=0: load -> Stall for 1 cycle, Ready in cycle 1, data correct.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding,
// wait-counter width, alignment mask and the request legality check.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_t;

    // Wait-state counter width; covers WAIT_STATES in 0..15.
    localparam int CNT_W = 4;

    // Low byte-address bits required for a word-aligned access.
    localparam logic [1:0] ALIGN_MASK = 2'b00;

    // A request is rejected when it is misaligned or asks for both a
    // load and a store at the same time.
    function automatic logic is_illegal(input logic rd,
                                        input logic wr,
                                        input logic [1:0] addr_lo);
        return (rd & wr) | (addr_lo != ALIGN_MASK);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM: synchronous write, synchronous registered read.
// Only the read-data register is reset; the storage itself is not.
module dmem_array #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

    // Store path: write the addressed word when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Load path: register the addressed word and hold it until the next read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder on the processor load/store port. A legal request
// stalls the processor for WAIT_STATES+1 cycles, commits to the RAM on the
// edge leaving the last wait cycle, then pulses Ready for one cycle. Illegal
// requests (misaligned or read+write) skip the RAM and answer with AddrErr.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_STATES = 2
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [31:0]           Addr,
    input  logic [DATA_WIDTH-1:0] WriteData,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic                  Ready,
    output logic                  Stall,
    output logic                  AddrErr
);

    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_STATES);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(1);
    localparam bit               NO_WAIT   = (WAIT_STATES == 0);

    state_t                  state_q;
    state_t                  state_d;
    logic [CNT_W-1:0]        cnt_q;
    logic                    err_q;

    // Request captured in IDLE; data path registers carry no reset.
    logic [ADDR_WIDTH-1:0]   idx_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    write_q;

    logic                    req;
    logic                    illegal;
    logic                    start;
    logic                    commit;
    logic [ADDR_WIDTH-1:0]   live_idx;
    logic [ADDR_WIDTH-1:0]   ram_idx;
    logic [DATA_WIDTH-1:0]   ram_wdata;
    logic                    ram_write;
    logic                    ram_we;
    logic                    ram_re;
    logic                    unused_addr_hi;

    assign req      = MemRead | MemWrite;
    assign illegal  = is_illegal(MemRead, MemWrite, Addr[1:0]);
    assign start    = (state_q == IDLE) && req;
    assign live_idx = Addr[ADDR_WIDTH+1:2];

    // Upper address bits alias onto the same words and are deliberately dropped.
    assign unused_addr_hi = ^Addr[31:ADDR_WIDTH+2];

    // State register.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: legal requests go through WAIT unless there are no
    // wait states; illegal requests answer directly.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (illegal || NO_WAIT) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: processor-facing handshake and the RAM commit strobe.
    always_comb begin
        Stall   = start || (state_q == WAIT);
        Ready   = (state_q == RESP);
        AddrErr = (state_q == RESP) && err_q;
        commit  = (start && !illegal && NO_WAIT) ||
                  ((state_q == WAIT) && (cnt_q == CNT_LAST));
    end

    // Wait counter and error flag, loaded when a request is accepted.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else if (start) begin
            cnt_q <= WAIT_INIT;
            err_q <= illegal;
        end else if (state_q == WAIT) begin
            cnt_q <= cnt_q - CNT_LAST;
        end
    end

    // Request capture; the processor holds these stable while stalled.
    always_ff @(posedge CLK) begin
        if (start) begin
            idx_q   <= live_idx;
            wdata_q <= WriteData;
            write_q <= MemWrite;
        end
    end

    // RAM port source: live inputs when committing straight from IDLE
    // (zero wait states), captured request otherwise.
    always_comb begin
        if (state_q == IDLE) begin
            ram_idx   = live_idx;
            ram_wdata = WriteData;
            ram_write = MemWrite;
        end else begin
            ram_idx   = idx_q;
            ram_wdata = wdata_q;
            ram_write = write_q;
        end
        ram_we = commit && ram_write;
        ram_re = commit && !ram_write;
    end

    dmem_array #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_array (
        .clk   (CLK),
        .rst_n (Reset),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_idx),
        .wdata (ram_wdata),
        .rdata (ReadData)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a WAIT_STATES=2 instance carries
// most scenarios, a WAIT_STATES=0 instance covers the no-wait timeline.
module tb_dmem_responder;

    typedef struct packed {
        logic [7:0]  stall;
        logic [7:0]  rdy;
        logic        err;
        logic [31:0] rdata;
    } resp_t;

    localparam int WS = 2;

    logic        clk;
    logic        rst_n;
    logic        rd0, wr0, rd1, wr1;
    logic [31:0] a0, d0, a1, d1;
    logic [31:0] rdat0, rdat1;
    logic        rdy0, st0, er0, rdy1, st1, er1;

    int          cmp_n;
    int          fail_n;
    resp_t       exp_q[$];
    logic [31:0] mem_m [0:255];
    logic [31:0] last_rd;
    bit          rd_known;

    dmem_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .WAIT_STATES(WS)) dut0 (
        .CLK(clk), .Reset(rst_n), .MemRead(rd0), .MemWrite(wr0), .Addr(a0),
        .WriteData(d0), .ReadData(rdat0), .Ready(rdy0), .Stall(st0), .AddrErr(er0)
    );

    dmem_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .WAIT_STATES(0)) dut1 (
        .CLK(clk), .Reset(rst_n), .MemRead(rd1), .MemWrite(wr1), .Addr(a1),
        .WriteData(d1), .ReadData(rdat1), .Ready(rdy1), .Stall(st1), .AddrErr(er1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic resp_t mk(input int s, input int r, input logic e, input logic [31:0] d);
        resp_t t;
        t.stall = 8'(s);
        t.rdy   = 8'(r);
        t.err   = e;
        t.rdata = d;
        return t;
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'(a[9:2]);
    endfunction

    // Drive one request from posedge+1, count Stall cycles, record the cycle
    // Ready appears plus AddrErr/ReadData, release the request after Ready.
    task automatic access(input bit sel, input bit rd, input bit wr,
                          input logic [31:0] a, input logic [31:0] d, output resp_t o);
        int stall_n;
        int rdy_c;
        logic er;
        logic [31:0] rv;
        stall_n = 0; rdy_c = -1; er = 1'b0; rv = '0;
        if (sel) begin rd1 = rd; wr1 = wr; a1 = a; d1 = d; end
        else     begin rd0 = rd; wr0 = wr; a0 = a; d0 = d; end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (sel ? st1 : st0) stall_n++;
            if (sel ? rdy1 : rdy0) begin
                rdy_c = c;
                er = sel ? er1 : er0;
                rv = sel ? rdat1 : rdat0;
            end
            @(posedge clk); #1;
            if (rdy_c >= 0) break;
        end
        rd0 = 1'b0; wr0 = 1'b0; rd1 = 1'b0; wr1 = 1'b0;
        o = mk(stall_n, rdy_c, er, rv);
    endtask

    task automatic test_reset();
        resp_t o, e;
        rst_n = 1'b0; rd0 = 1'b1; wr0 = 1'b0; a0 = 32'h40; d0 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        cmp_n++; if (rdat0 !== 32'h0) begin fail_n++; $display("FAIL reset_rdata: got %h want 0", rdat0); end
        cmp_n++; if (rdy0 !== 1'b0) begin fail_n++; $display("FAIL reset_ready: got %b want 0", rdy0); end
        cmp_n++; if (er0 !== 1'b0) begin fail_n++; $display("FAIL reset_addrerr: got %b want 0", er0); end
        cmp_n++; if (dut0.state_q !== 2'b00) begin fail_n++; $display("FAIL reset_state: got %b want 00", dut0.state_q); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        cmp_n++; if (st0 !== 1'b1) begin fail_n++; $display("FAIL release_stall: got %b want 1", st0); end
        last_rd = '0;
        rd_known = 1'b0;
        exp_q.push_back(mk(WS + 1, WS + 1, 1'b0, '0));
        access(1'b0, 1'b1, 1'b0, 32'h40, '0, o);
        e = exp_q.pop_front();
        cmp_n++; if (o[48:32] !== e[48:32]) begin fail_n++; $display("FAIL reset_first_load: got %h want %h", o[48:32], e[48:32]); end
    endtask

    task automatic test_idle();
        repeat (3) begin
            @(negedge clk);
            cmp_n++; if ({st0, rdy0, er0} !== 3'b000) begin fail_n++; $display("FAIL idle_outputs: got %b want 000", {st0, rdy0, er0}); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_store_load();
        resp_t o, e;
        mem_m[widx(32'h10)] = 32'hDEADBEEF;
        exp_q.push_back(mk(WS + 1, WS + 1, 1'b0, last_rd));
        access(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, o);
        e = exp_q.pop_front();
        cmp_n++; if (o[48:32] !== e[48:32]) begin fail_n++; $display("FAIL store_10: got %h want %h", o, e); end
        last_rd = mem_m[widx(32'h10)]; rd_known = 1'b1;
        exp_q.push_back(mk(WS + 1, WS + 1, 1'b0, last_rd));
        access(1'b0, 1'b1, 1'b0, 32'h10, '0, o);
        e = exp_q.pop_front();
        cmp_n++; if (o !== e) begin fail_n++; $display("FAIL load_10: got %h want %h", o, e); end
    endtask

    task automatic test_misaligned();
        resp_t o, e;
        exp_q.push_back(mk(1, 1, 1'b1, last_rd));
        access(1'b0, 1'b1, 1'b0, 32'h13, '0, o);
        e = exp_q.pop_front();
        cmp_n++; if (o !== e) begin fail_n++; $display("FAIL misaligned_load: got %h want %h", o, e); end
        exp_q.push_back(mk(1, 1, 1'b1, last_rd));
        access(1'b0, 1'b0, 1'b1, 32'h12, 32'h1, o);
        e = exp_q.pop_front();
        cmp_n++; if (o !== e) begin fail_n++; $display("FAIL misaligned_store: got %h want %h", o, e); end
        last_rd = mem_m[widx(32'h10)];
        exp_q.push_back(mk(WS + 1, WS + 1, 1'b0, last_rd));
        access(1'b0, 1'b1, 1'b0, 32'h10, '0, o);
        e = exp_q.pop_front();
        cmp_n++; if (o !== e) begin fail_n++; $display("FAIL load_after_misaligned: got %h want %h", o, e); end
    endtask

    task automatic test_read_write_both();
        resp_t o, e;
        mem_m[widx(32'h20)] = 32'hA5A50020;
        exp_q.push_back(mk(WS + 1, WS + 1, 1'b0, last_rd));
        access(1'b0, 1'b0, 1'b1, 32'h20, 32'hA5A50020, o);
        e = exp_q.pop_front();
        cmp_n++; if (o !== e) begin fail_n++; $display("FAIL store_20: got %h want %h", o, e); end
        exp_q.push_back(mk(1, 1, 1'b1, last_rd));
        access(1'b0, 1'b1, 1'b1, 32'h20, 32'h55, o);
        e = exp_q.pop_front();
        cmp_n++; if (o !== e) begin fail_n++; $display("FAIL rd_wr_both: got %h want %h", o, e); end
        last_rd = mem_m[widx(32'h20)];
        exp_q.push_back(mk(WS + 1, WS + 1, 1'b0, last_rd));
        access(1'b0, 1'b1, 1'b0, 32'h20, '0, o);
        e = exp_q.pop_front();
        cmp_n++; if (o !== e) begin fail_n++; $display("FAIL load_20_unchanged: got %h want %h", o, e); end
    endtask

    task automatic test_alias();
        resp_t o, e;
        mem_m[widx(32'h410)] = 32'h12345678;
        exp_q.push_back(mk(WS + 1, WS + 1, 1'b0, last_rd));
        access(1'b0, 1'b0, 1'b1, 32'h410, 32'h12345678, o);
        e = exp_q.pop_front();
        cmp_n++; if (o !== e) begin fail_n++; $display("FAIL store_410: got %h want %h", o, e); end
        last_rd = mem_m[widx(32'h10)];
        exp_q.push_back(mk(WS + 1, WS + 1, 1'b0, last_rd));
        access(1'b0, 1'b1, 1'b0, 32'h10, '0, o);
        e = exp_q.pop_front();
        cmp_n++; if (o !== e) begin fail_n++; $display("FAIL alias_load_10: got %h want %h", o, e); end
    endtask

    task automatic test_back_to_back();
        resp_t o, e;
        mem_m[widx(32'h44)] = 32'h11111111;
        mem_m[widx(32'h48)] = 32'h22222222;
        exp_q.push_back(mk(WS + 1, WS + 1, 1'b0, last_rd));
        exp_q.push_back(mk(WS + 1, WS + 1, 1'b0, last_rd));
        exp_q.push_back(mk(WS + 1, WS + 1, 1'b0, mem_m[widx(32'h44)]));
        access(1'b0, 1'b0, 1'b1, 32'h44, 32'h11111111, o);
        e = exp_q.pop_front();
        cmp_n++; if (o !== e) begin fail_n++; $display("FAIL b2b_store_44: got %h want %h", o, e); end
        access(1'b0, 1'b0, 1'b1, 32'h48, 32'h22222222, o);
        e = exp_q.pop_front();
        cmp_n++; if (o !== e) begin fail_n++; $display("FAIL b2b_store_48: got %h want %h", o, e); end
        access(1'b0, 1'b1, 1'b0, 32'h44, '0, o);
        e = exp_q.pop_front();
        cmp_n++; if (o !== e) begin fail_n++; $display("FAIL b2b_load_44: got %h want %h", o, e); end
        last_rd = mem_m[widx(32'h44)];
    endtask

    task automatic test_reset_mid_access();
        resp_t o, e;
        mem_m[widx(32'h30)] = 32'h1;
        exp_q.push_back(mk(WS + 1, WS + 1, 1'b0, last_rd));
        access(1'b0, 1'b0, 1'b1, 32'h30, 32'h1, o);
        e = exp_q.pop_front();
        cmp_n++; if (o !== e) begin fail_n++; $display("FAIL store_30: got %h want %h", o, e); end
        // Store that never reaches its commit edge.
        a0 = 32'h30; d0 = 32'hCAFEF00D; wr0 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        cmp_n++; if (rdat0 !== 32'h0) begin fail_n++; $display("FAIL midreset_rdata: got %h want 0", rdat0); end
        wr0 = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        last_rd = mem_m[widx(32'h30)];
        exp_q.push_back(mk(WS + 1, WS + 1, 1'b0, last_rd));
        access(1'b0, 1'b1, 1'b0, 32'h30, '0, o);
        e = exp_q.pop_front();
        cmp_n++; if (o !== e) begin fail_n++; $display("FAIL load_30_after_reset: got %h want %h", o, e); end
    endtask

    task automatic test_zero_wait();
        resp_t o, e;
        exp_q.push_back(mk(1, 1, 1'b0, 32'h0));
        access(1'b1, 1'b0, 1'b1, 32'h8, 32'h0BADF00D, o);
        e = exp_q.pop_front();
        cmp_n++; if (o !== e) begin fail_n++; $display("FAIL ws0_store_8: got %h want %h", o, e); end
        exp_q.push_back(mk(1, 1, 1'b0, 32'h0BADF00D));
        access(1'b1, 1'b1, 1'b0, 32'h8, '0, o);
        e = exp_q.pop_front();
        cmp_n++; if (o !== e) begin fail_n++; $display("FAIL ws0_load_8: got %h want %h", o, e); end
        exp_q.push_back(mk(1, 1, 1'b1, 32'h0BADF00D));
        access(1'b1, 1'b1, 1'b0, 32'h9, '0, o);
        e = exp_q.pop_front();
        cmp_n++; if (o !== e) begin fail_n++; $display("FAIL ws0_misaligned: got %h want %h", o, e); end
    endtask

    initial begin
        cmp_n = 0; fail_n = 0;
        rd0 = 1'b0; wr0 = 1'b0; a0 = '0; d0 = '0;
        rd1 = 1'b0; wr1 = 1'b0; a1 = '0; d1 = '0;
        rst_n = 1'b0;
        test_reset();
        test_idle();
        test_store_load();
        test_misaligned();
        test_read_write_both();
        test_alias();
        test_back_to_back();
        test_reset_mid_access();
        test_zero_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
        $finish;
    end

endmodule
